mem_arbiter: RTL

//  Shares the single-port system RAM between the 6502 core and a secondary bus

---
 rtl/mem_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port synchronous RAM between the 6502 core and a
// secondary bus master (DMA). The CPU owns the bus by default; DMA steals whole
// cycles, limited to DMA_BURST consecutive grants before one forced CPU cycle.
// Read data returns the cycle after the access and is held per master.
module mem_arbiter #(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 8,
  parameter int unsigned DMA_BURST = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cpu_rw_i,
  input  logic [AW-1:0] cpu_ad_i,
  input  logic [DW-1:0] cpu_dout_i,
  output logic [DW-1:0] cpu_din_o,
  output logic          cpu_rdy_o,
  input  logic          dma_req_i,
  input  logic          dma_rw_i,
  input  logic [AW-1:0] dma_ad_i,
  input  logic [DW-1:0] dma_dout_i,
  output logic          dma_gnt_o,
  output logic [DW-1:0] dma_din_o,
  output logic          dma_ack_o,
  output logic          ram_rw_o,
  output logic [AW-1:0] ram_a_o,
  output logic [DW-1:0] ram_dout_o,
  input  logic [DW-1:0] ram_din_i
);

  // DMA_BURST=0 still needs a 1-bit counter; it simply never leaves zero.
  localparam int unsigned CntW = (DMA_BURST > 0) ? $clog2(DMA_BURST + 1) : 1;
  localparam logic [CntW-1:0] BurstMax = CntW'(DMA_BURST);

  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
  logic            last_dma_q, last_dma_d;   // 1: previous cycle owned by DMA
  logic            last_rd_q, last_rd_d;     // previous cycle was a RAM read
  logic [DW-1:0]   cpu_hold_q, cpu_hold_d;
  logic [DW-1:0]   dma_hold_q, dma_hold_d;
  logic            dma_ack_q, dma_ack_d;

  // State register: slot counter, ownership history and per-master read holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      burst_cnt_q <= '0;
      last_dma_q  <= 1'b0;
      last_rd_q   <= 1'b0;
      cpu_hold_q  <= '0;
      dma_hold_q  <= '0;
      dma_ack_q   <= 1'b0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      last_dma_q  <= last_dma_d;
      last_rd_q   <= last_rd_d;
      cpu_hold_q  <= cpu_hold_d;
      dma_hold_q  <= dma_hold_d;
      dma_ack_q   <= dma_ack_d;
    end
  end

  // Next state: count consecutive grants, any CPU cycle restarts the burst window.
  always_comb begin
    burst_cnt_d = '0;
    if (dma_gnt_o) begin
      burst_cnt_d = burst_cnt_q + CntW'(1);
    end
    last_dma_d = dma_gnt_o;
    last_rd_d  = ram_rw_o;
    dma_ack_d  = dma_gnt_o & dma_rw_i;
    // Holds follow the returned value, so they latch fresh data and keep it otherwise.
    cpu_hold_d = cpu_din_o;
    dma_hold_d = dma_din_o;
  end

  // Outputs: same-cycle grant, RAM bus mux and read-data routing.
  always_comb begin
    dma_gnt_o  = rst_ni & dma_req_i & (burst_cnt_q < BurstMax);
    cpu_rdy_o  = rst_ni & ~dma_gnt_o;
    ram_rw_o   = 1'b1;
    ram_a_o    = cpu_ad_i;
    ram_dout_o = cpu_dout_i;
    if (dma_gnt_o) begin
      ram_rw_o   = dma_rw_i;
      ram_a_o    = dma_ad_i;
      ram_dout_o = dma_dout_i;
    end else if (rst_ni) begin
      ram_rw_o = cpu_rw_i;
    end
    cpu_din_o = (!last_dma_q && last_rd_q) ? ram_din_i : cpu_hold_q;
    dma_din_o = (last_dma_q && last_rd_q) ? ram_din_i : dma_hold_q;
    dma_ack_o = dma_ack_q;
  end

endmodule
